// File: rtl/es_mem_req.sv
// es_mem_req: EX-stage data SRAM request generator with in-flight response tracking.
// Define ES_UNALIGNED_LS_EN to enable lwl/lwr/swl/swr; otherwise those codes act as no-ops.
module es_mem_req (
    input  logic        clk,
    input  logic        reset,
    input  logic        es_valid,
    input  logic        ms_allowin,
    input  logic [3:0]  mem_op,
    input  logic [31:0] addr,
    input  logic [31:0] rt_value,
    input  logic        flush,
    input  logic        ms_ex,
    output logic        data_sram_req,
    output logic        data_sram_wr,
    output logic [1:0]  data_sram_size,
    output logic [3:0]  data_sram_wstrb,
    output logic [31:0] data_sram_addr,
    output logic [31:0] data_sram_wdata,
    input  logic        data_sram_addr_ok,
    input  logic        data_sram_data_ok,
    output logic        data_ok_to_ms,
    output logic        es_ready_go,
    output logic        ale,
    output logic [4:0]  ale_excode,
    output logic [1:0]  whb_mux
);

    typedef enum logic [1:0] {S_IDLE, S_REQ, S_DONE} state_t;

    localparam logic [3:0] OP_LB  = 4'd1;
    localparam logic [3:0] OP_LBU = 4'd2;
    localparam logic [3:0] OP_LH  = 4'd3;
    localparam logic [3:0] OP_LHU = 4'd4;
    localparam logic [3:0] OP_LW  = 4'd5;
    localparam logic [3:0] OP_LWL = 4'd6;
    localparam logic [3:0] OP_LWR = 4'd7;
    localparam logic [3:0] OP_SB  = 4'd8;
    localparam logic [3:0] OP_SH  = 4'd9;
    localparam logic [3:0] OP_SW  = 4'd10;
    localparam logic [3:0] OP_SWL = 4'd11;
    localparam logic [3:0] OP_SWR = 4'd12;

    state_t     state_q, state_d;
    logic [1:0] out_cnt_q, out_cnt_d;
    logic [1:0] discard_cnt_q, discard_cnt_d;
    logic       cancel_pend_q, cancel_pend_d;

    logic       op_load, op_store, op_mem, word_align;
    logic       fire, cancel, req_accept, resp_dec, discard_dec;
    logic [1:0] a;

    assign a       = addr[1:0];
    assign whb_mux = a;

    // NOTE: every signal driven here gets a default first, so no decode path can infer a latch.
    always_comb begin
        op_load         = 1'b0;
        op_store        = 1'b0;
        word_align      = 1'b0;
        data_sram_size  = 2'd0;
        data_sram_wstrb = 4'b0000;
        data_sram_wdata = rt_value;
        case (mem_op)
            OP_LB, OP_LBU: op_load = 1'b1;
            OP_LH, OP_LHU: begin
                op_load        = 1'b1;
                data_sram_size = 2'd1;
            end
            OP_LW: begin
                op_load        = 1'b1;
                data_sram_size = 2'd2;
            end
`ifdef ES_UNALIGNED_LS_EN
            OP_LWL, OP_LWR: begin
                op_load        = 1'b1;
                data_sram_size = 2'd2;
                word_align     = 1'b1;
            end
`endif
            OP_SB: begin
                op_store        = 1'b1;
                data_sram_wstrb = 4'b0001 << a;
                data_sram_wdata = {4{rt_value[7:0]}};
            end
            OP_SH: begin
                op_store        = 1'b1;
                data_sram_size  = 2'd1;
                data_sram_wstrb = a[1] ? 4'b1100 : 4'b0011;
                data_sram_wdata = {2{rt_value[15:0]}};
            end
            OP_SW: begin
                op_store        = 1'b1;
                data_sram_size  = 2'd2;
                data_sram_wstrb = 4'b1111;
            end
`ifdef ES_UNALIGNED_LS_EN
            // swl keeps the high bytes of rt at the low end; ~a == 3 - a for a 2-bit offset.
            OP_SWL: begin
                op_store        = 1'b1;
                data_sram_size  = 2'd2;
                word_align      = 1'b1;
                data_sram_wstrb = 4'b1111 >> (~a);
                data_sram_wdata = rt_value >> {~a, 3'b000};
            end
            OP_SWR: begin
                op_store        = 1'b1;
                data_sram_size  = 2'd2;
                word_align      = 1'b1;
                data_sram_wstrb = 4'b1111 << a;
                data_sram_wdata = rt_value << {a, 3'b000};
            end
`endif
            default: ;
        endcase
    end

    assign op_mem         = op_load | op_store;
    assign data_sram_wr   = op_store;
    assign data_sram_addr = word_align ? {addr[31:2], 2'b00} : addr;
    assign data_sram_req  = (state_q == S_REQ);

    assign ale = es_valid &
                 ((((mem_op == OP_LH) | (mem_op == OP_LHU) | (mem_op == OP_SH)) & addr[0]) |
                  (((mem_op == OP_LW) | (mem_op == OP_SW)) & (a != 2'b00)));
    assign ale_excode = op_store ? 5'h05 : 5'h04;

    assign es_ready_go = (!op_mem | ale | ms_ex) ? 1'b1
                       : ((data_sram_req & data_sram_addr_ok) | (state_q == S_DONE));
    assign fire        = es_valid & es_ready_go & ms_allowin;
    assign cancel      = cancel_pend_q | flush;
    assign req_accept  = data_sram_req & data_sram_addr_ok;
    assign resp_dec    = data_sram_data_ok & (out_cnt_q != 2'd0);
    assign discard_dec = data_sram_data_ok & (discard_cnt_q != 2'd0);

    assign data_ok_to_ms = data_sram_data_ok & (discard_cnt_q == 2'd0) & ~reset;

    always_comb begin
        state_d       = state_q;
        cancel_pend_d = cancel_pend_q;
        case (state_q)
            S_IDLE: begin
                if (es_valid & op_mem & !ale & !flush & !ms_ex & (out_cnt_q < 2'd2))
                    state_d = S_REQ;
            end
            S_REQ: begin
                // A request already on the bus cannot be withdrawn; a flush only marks it for discard.
                if (data_sram_addr_ok) begin
                    state_d       = (cancel | fire) ? S_IDLE : S_DONE;
                    cancel_pend_d = 1'b0;
                end else if (flush) begin
                    cancel_pend_d = 1'b1;
                end
            end
            S_DONE: begin
                if (fire | flush)
                    state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        out_cnt_d = out_cnt_q;
        if (req_accept & !resp_dec)
            out_cnt_d = out_cnt_q + 2'd1;
        else if (!req_accept & resp_dec)
            out_cnt_d = out_cnt_q - 2'd1;

        discard_cnt_d = discard_cnt_q;
        if (discard_dec)
            discard_cnt_d = discard_cnt_q - 2'd1;
        if (req_accept & cancel)
            discard_cnt_d = discard_cnt_d + 2'd1;
        // Same-cycle data_ok is already folded into out_cnt_d, so only the remainder is discarded.
        if (flush & (state_q != S_REQ))
            discard_cnt_d = out_cnt_d;
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= S_IDLE;
            out_cnt_q     <= 2'd0;
            discard_cnt_q <= 2'd0;
            cancel_pend_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            out_cnt_q     <= out_cnt_d;
            discard_cnt_q <= discard_cnt_d;
            cancel_pend_q <= cancel_pend_d;
        end
    end

endmodule
